// File: rtl/dff_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dff_mux_arbiter_if
// Purpose  : Bundle of request/grant/tag signals between the two requesters
//            (and the downstream dff_mux) and the dff_mux_arbiter.
// Ports    : req_a, req_b      - level requests, held until served
//            gnt_a, gnt_b      - registered one-hot grants
//            sel               - dff_mux select (1 = a, 0 = b)
//            out_valid/out_src - tag of the sample currently on dff_mux out
//            burst_cnt, sw_cnt - burst length and handover statistics
// Modports : master - requester side (drives requests)
//            slave  - arbiter side (drives grants, select and tags)
// Revision : 1.0 - initial release
// ============================================================================
interface dff_mux_arbiter_if #(
    parameter int CNT_W = 3,
    parameter int SW_W  = 8
);
    logic             req_a;
    logic             req_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic             out_valid;
    logic             out_src;
    logic [CNT_W-1:0] burst_cnt;
    logic [SW_W-1:0]  sw_cnt;

    modport master (
        output req_a, req_b,
        input  gnt_a, gnt_b, sel, out_valid, out_src, burst_cnt, sw_cnt
    );

    modport slave (
        input  req_a, req_b,
        output gnt_a, gnt_b, sel, out_valid, out_src, burst_cnt, sw_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dff_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_mux_arbiter
// Purpose  : Round-robin arbiter that shares one registered 2:1 mux
//            (out <= sel ? a : b) between requesters A and B, with bounded
//            bursts under contention and tagging of the registered mux output.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - dff_mux_arbiter_if.slave (requests in; grants, sel,
//                    out_valid, out_src, burst_cnt, sw_cnt out)
// Revision : 1.0 - initial release
// ============================================================================
module dff_mux_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3,
    parameter int SW_W      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dff_mux_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [SW_W-1:0]  C_SW_MAX    = '1;
    localparam logic [SW_W-1:0]  C_SW_ONE    = SW_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SW_W-1:0]  r_sw_cnt;
    logic             r_last_a;      // 1: last owner was A, 0: last owner was B
    logic             w_last_a_next;
    logic             w_handover;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_sel;
    logic             r_out_valid;
    logic             r_out_src;

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_burst_cnt;
        w_last_a_next = r_last_a;
        w_handover    = 1'b0;

        case (r_state)
            IDLE: begin
                // On a tie the requester that did not own the mux last wins.
                if (bus.req_a && (!bus.req_b || !r_last_a)) begin
                    w_next     = OWN_A;
                    w_cnt_next = C_CNT_ONE;
                end else if (bus.req_b) begin
                    w_next     = OWN_B;
                    w_cnt_next = C_CNT_ONE;
                end
            end

            OWN_A: begin
                if (!bus.req_a || (bus.req_b && r_burst_cnt == C_MAX_BURST)) begin
                    w_last_a_next = 1'b1;
                    if (bus.req_b) begin
                        w_next     = OWN_B;
                        w_cnt_next = C_CNT_ONE;
                        w_handover = 1'b1;
                    end else begin
                        w_next     = IDLE;
                        w_cnt_next = '0;
                    end
                end else if (r_burst_cnt != C_MAX_BURST) begin
                    w_cnt_next = r_burst_cnt + C_CNT_ONE;
                end
            end

            OWN_B: begin
                if (!bus.req_b || (bus.req_a && r_burst_cnt == C_MAX_BURST)) begin
                    w_last_a_next = 1'b0;
                    if (bus.req_a) begin
                        w_next     = OWN_A;
                        w_cnt_next = C_CNT_ONE;
                        w_handover = 1'b1;
                    end else begin
                        w_next     = IDLE;
                        w_cnt_next = '0;
                    end
                end else if (r_burst_cnt != C_MAX_BURST) begin
                    w_cnt_next = r_burst_cnt + C_CNT_ONE;
                end
            end

            default: begin
                w_next     = IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_last_a    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_burst_cnt <= w_cnt_next;
            r_last_a    <= w_last_a_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. Grants and sel are decoded from the next state so
    // they appear together with the state that owns them; sel holds in IDLE.
    // The output tags lag the grants by one cycle to line up with the
    // sample dff_mux registers on the edge after sel becomes valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_src   <= 1'b0;
            r_sw_cnt    <= '0;
        end else begin
            r_gnt_a     <= (w_next == OWN_A);
            r_gnt_b     <= (w_next == OWN_B);
            if (w_next == OWN_A) begin
                r_sel <= 1'b1;
            end else if (w_next == OWN_B) begin
                r_sel <= 1'b0;
            end
            r_out_valid <= r_gnt_a | r_gnt_b;
            r_out_src   <= r_gnt_a;
            if (w_handover && r_sw_cnt != C_SW_MAX) begin
                r_sw_cnt <= r_sw_cnt + C_SW_ONE;
            end
        end
    end

    assign bus.gnt_a     = r_gnt_a;
    assign bus.gnt_b     = r_gnt_b;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_src   = r_out_src;
    assign bus.burst_cnt = r_burst_cnt;
    assign bus.sw_cnt    = r_sw_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dff_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_mux_arbiter
// Purpose  : Self-checking bench for dff_mux_arbiter. Two instances run from
//            the same requests: dut0 (MAX_BURST=4, SW_W=8) and dut1
//            (MAX_BURST=1, SW_W=2). Each feeds a behavioural dff_mux with
//            a=1, b=0 so the registered mux output must equal out_src.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_mux_arbiter;

    localparam int CNT_W  = 3;
    localparam int MAXB0  = 4;
    localparam int SW_W0  = 8;
    localparam int MAXB1  = 1;
    localparam int SW_W1  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dff_mux_arbiter_if #(.CNT_W(CNT_W), .SW_W(SW_W0)) bus0 ();
    dff_mux_arbiter_if #(.CNT_W(CNT_W), .SW_W(SW_W1)) bus1 ();

    dff_mux_arbiter #(.MAX_BURST(MAXB0), .CNT_W(CNT_W), .SW_W(SW_W0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    dff_mux_arbiter #(.MAX_BURST(MAXB1), .CNT_W(CNT_W), .SW_W(SW_W1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Behavioural dff_mux per instance: out <= sel ? a : b with a=1, b=0.
    logic data_a = 1'b1;
    logic data_b = 1'b0;
    logic mux0, mux1;
    always @(posedge clk) begin
        mux0 <= bus0.sel ? data_a : data_b;
        mux1 <= bus1.sel ? data_a : data_b;
    end

    // ------------------------------------------------------------------
    // Reference model: owner 0=none, 1=A, 2=B
    // ------------------------------------------------------------------
    typedef struct {
        int owner;
        int cnt;
        int last;
        int sw;
        int sel;
        int ga;
        int gb;
        int ov;
        int os;
    } mstate_t;

    mstate_t m [2];
    mstate_t q [2][$];
    int      maxb  [2] = '{MAXB0, MAXB1};
    int      swmax [2] = '{(1 << SW_W0) - 1, (1 << SW_W1) - 1};

    int n_tests = 0;
    int n_fail  = 0;

    function automatic mstate_t reset_state();
        mstate_t s;
        s.owner = 0; s.cnt = 0; s.last = 2; s.sw = 0; s.sel = 0;
        s.ga = 0; s.gb = 0; s.ov = 0; s.os = 0;
        return s;
    endfunction

    function automatic mstate_t advance(mstate_t s, bit ra, bit rb, int mb, int smax);
        mstate_t n = s;
        bit mine, other;
        n.ov = (s.ga != 0 || s.gb != 0) ? 1 : 0;
        n.os = s.ga;
        if (s.owner == 0) begin
            if (ra && rb)  n.owner = (s.last == 1) ? 2 : 1;
            else if (ra)   n.owner = 1;
            else if (rb)   n.owner = 2;
            if (n.owner != 0) n.cnt = 1;
        end else begin
            mine  = (s.owner == 1) ? ra : rb;
            other = (s.owner == 1) ? rb : ra;
            if (mine && !(other && s.cnt == mb)) begin
                n.cnt = (s.cnt < mb) ? s.cnt + 1 : mb;
            end else begin
                n.last = s.owner;
                if (other) begin
                    n.owner = 3 - s.owner;
                    n.cnt   = 1;
                    n.sw    = (s.sw < smax) ? s.sw + 1 : smax;
                end else begin
                    n.owner = 0;
                    n.cnt   = 0;
                end
            end
        end
        n.ga = (n.owner == 1) ? 1 : 0;
        n.gb = (n.owner == 2) ? 1 : 0;
        if (n.owner == 1)      n.sel = 1;
        else if (n.owner == 2) n.sel = 0;
        return n;
    endfunction

    function automatic logic [20:0] pack(mstate_t e);
        return {e.ga[0], e.gb[0], e.sel[0], e.ov[0], e.os[0], e.cnt[7:0], e.sw[7:0]};
    endfunction

    // Advance the model on a clock edge and queue what the DUTs must show.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) m[i] = reset_state();
            else        m[i] = advance(m[i], bus0.req_a, bus0.req_b, maxb[i], swmax[i]);
            q[i].push_back(m[i]);
        end
    endtask

    task automatic step(input bit a, input bit b);
        bus0.req_a = a; bus0.req_b = b;
        bus1.req_a = a; bus1.req_b = b;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one expected record per DUT per cycle, away from posedge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [20:0] act, exp_v;
        mstate_t     e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0)
                act = {bus0.gnt_a, bus0.gnt_b, bus0.sel, bus0.out_valid, bus0.out_src,
                       8'(bus0.burst_cnt), 8'(bus0.sw_cnt)};
            else
                act = {bus1.gnt_a, bus1.gnt_b, bus1.sel, bus1.out_valid, bus1.out_src,
                       8'(bus1.burst_cnt), 8'(bus1.sw_cnt)};
            if (q[i].size() > 0) begin
                e     = q[i].pop_front();
                exp_v = pack(e);
                n_tests++;
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs dut%0d t=%0t {ga,gb,sel,ov,os,cnt,sw} actual=%b_%b_%b_%b_%b_%0d_%0d required=%b_%b_%b_%b_%b_%0d_%0d",
                             i, $time, act[20], act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                             exp_v[20], exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
                end
            end
            // one-hot grants
            n_tests++;
            if (act[20] && act[19]) begin
                n_fail++;
                $display("FAIL onehot dut%0d t=%0t actual gnt_a=1 gnt_b=1 required at most one", i, $time);
            end
            // registered mux sample must come from the tagged source
            if (act[17] === 1'b1) begin
                n_tests++;
                if ((i == 0 ? mux0 : mux1) !== act[16]) begin
                    n_fail++;
                    $display("FAIL datapath dut%0d t=%0t actual mux_out=%b required=%b (out_src)",
                             i, $time, (i == 0 ? mux0 : mux1), act[16]);
                end
            end
        end
    end

    task automatic check_val(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [20:0] zero_vec;
        rst_n = 1'b0;
        m[0]  = reset_state();
        m[1]  = reset_state();

        // reset state held across two edges
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
        step(0, 0);

        // single requester A for 6 cycles
        for (int i = 0; i < 6; i++) step(1, 0);
        step(0, 0);
        step(0, 0);

        // tie: alternate bursts; long enough to saturate both sw counters
        for (int i = 0; i < 1100; i++) step(1, 1);
        check_val("sw_sat_dut0", int'(bus0.sw_cnt), 255);
        check_val("sw_sat_dut1", int'(bus1.sw_cnt), 3);

        // idle, then A only, then release-based handover to B
        step(0, 0);
        step(0, 0);
        for (int i = 0; i < 3; i++) step(1, 0);
        for (int i = 0; i < 4; i++) step(0, 1);
        step(0, 0);
        // re-arbitration after idle: both rise
        for (int i = 0; i < 3; i++) step(1, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // asynchronous reset in the middle of an A burst
        for (int i = 0; i < 3; i++) step(1, 0);
        check_val("pre_reset_gnt_a", int'(bus0.gnt_a), 1);
        #1;
        rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        m[0] = reset_state();
        m[1] = reset_state();
        #1;
        zero_vec = '0;
        check_val("async_reset_dut0",
                  int'({bus0.gnt_a, bus0.gnt_b, bus0.sel, bus0.out_valid, bus0.out_src,
                        8'(bus0.burst_cnt), 8'(bus0.sw_cnt)}), int'(zero_vec));
        check_val("async_reset_dut1",
                  int'({bus1.gnt_a, bus1.gnt_b, bus1.sel, bus1.out_valid, bus1.out_src,
                        8'(bus1.burst_cnt), 8'(bus1.sw_cnt)}), int'(zero_vec));
        @(posedge clk);
        model_edge();
        #2;
        rst_n = 1'b1;
        // both requesting right after release: A wins
        for (int i = 0; i < 6; i++) step(1, 1);

        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(0, 0);
        step(0, 0);

        // drain scoreboard within a bounded number of cycles
        for (int i = 0; i < 4; i++) begin
            if (q[0].size() != 0 || q[1].size() != 0) @(negedge clk);
        end
        #1;
        check_val("scoreboard_drained", q[0].size() + q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_mux_arbiter.md
Name: dff_mux_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one registered 2:1 mux (dff_mux: out <= sel ? a : b) between two requesters, A and B.
- Drives the mux select, issues one-hot grants with a bounded burst length and reports which source the registered mux output carries.
- Sits directly in front of dff_mux. Requesters present data on the mux a/b inputs while holding their grant.

Parameters:
- MAX_BURST, 4, maximum consecutive grant cycles to one requester while the other is requesting (legal range 1..2**CNT_W-1)
- CNT_W, 3, width of the burst counter
- SW_W, 8, width of the saturating handover counter

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset; asserts immediately, releases synchronously to clk
- req_a  input  1  requester A wants the mux; level, held until served
- req_b  input  1  requester B wants the mux; level, held until served
- gnt_a  output  1  A owns the mux this cycle (registered)
- gnt_b  output  1  B owns the mux this cycle (registered)
- sel  output  1  to dff_mux sel; 1 selects a, 0 selects b (registered)
- out_valid  output  1  dff_mux out holds a granted sample this cycle
- out_src  output  1  source of the current out sample: 1 = A, 0 = B; meaningful only when out_valid=1
- burst_cnt  output  CNT_W  cycles granted to the current owner, saturating at MAX_BURST
- sw_cnt  output  SW_W  number of ownership handovers A<->B since reset, saturating at all-ones

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; gnt_a=0, gnt_b=0, sel=0, out_valid=0, out_src=0, burst_cnt=0, sw_cnt=0. Internal last-owner register is set to B, so A wins the first tie.
- State machine: IDLE, OWN_A, OWN_B. All outputs are registered, with no combinational paths from req to outputs.
- Grant latency: a request sampled at edge N produces gnt_x=1 and the matching sel after edge N. The shortest path from req rising to gnt is 1 cycle.
- In OWN_A, gnt_a=1 and sel=1. In OWN_B, gnt_b=1 and sel=0. In IDLE both grants are 0 and sel holds its last value.
- Transitions from IDLE:
  - Only req_a set: go to OWN_A.
  - Only req_b set: go to OWN_B.
  - Both set: grant the requester that is not the last owner.
  - Neither set: stay in IDLE.
  - burst_cnt is loaded with 1 on entry to any OWN state.
- Transitions from OWN_A (OWN_B is symmetric):
  - req_a=0, req_b=1: go to OWN_B.
  - req_a=0, req_b=0: go to IDLE; burst_cnt=0.
  - req_a=1, req_b=1, burst_cnt==MAX_BURST: preempt to OWN_B.
  - req_a=1, any other case: stay in OWN_A; burst_cnt increments, saturating at MAX_BURST.
  - Going to OWN_B from OWN_A is a handover: it increments sw_cnt and sets last owner to A.
- Going to IDLE is not a handover. The last owner register updates on every exit from an OWN state.
- Uncontended owner: an owner with no competing request keeps the mux indefinitely. burst_cnt holds at MAX_BURST, so the owner is preempted on the first edge the other side requests.
- MAX_BURST=1 with both requesting: grants alternate every cycle.
- Output tagging: dff_mux registers a/b on the edge after sel is valid. Therefore out_valid = gnt_a|gnt_b delayed one cycle, and out_src = gnt_a delayed one cycle.
- sw_cnt stops at 2**SW_W-1 and does not wrap.
- Reset mid-burst: grants drop in the same cycle rst_n falls. After release, the arbiter restarts from IDLE with A priority. One out_valid=0 cycle always follows reset release.
- gnt_a and gnt_b are never both 1 in any cycle, including around reset.

Test Plan:
- Reset: drive rst_n=0 mid-cycle while gnt_a=1 -> all outputs 0 before the next clk edge; after release, out_valid=0 for at least 1 cycle.
- Single requester: req_a=1 for 6 cycles from cycle 0 -> gnt_a=1 and sel=1 from cycle 1 to cycle 6; out_valid=1, out_src=1 from cycle 2; burst_cnt saturates at 4; sw_cnt=0.
- Tie after reset: req_a=req_b=1 held with MAX_BURST=4 -> pattern A,A,A,A,B,B,B,B,A...; sel follows 1111000011...; sw_cnt increments at each switch.
- Release-based handover: OWN_A, then req_a drops while req_b=1 -> gnt_b=1 next cycle, sel=0, sw_cnt+1; the out_src=0 sample appears one cycle later.
- Idle and re-arbitration: both requests drop -> IDLE, grants 0, sel held. Then both rise with last owner=B -> A is granted.
- Data path check with dff_mux instantiated: a=1, b=0 under alternating grants with MAX_BURST=1 -> out toggles 1,0,1,0 with out_src matching every out_valid cycle. Run sw_cnt saturation with SW_W=2 -> holds at 3.
